// File: rtl/pipe_ctrl_if.sv
// Interface between the pipeline controller and the rest of the core.
// The master modport is the core side and the slave modport is the controller.
interface pipe_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic                  id_stallreq_i;
  logic                  ex_jump_flag_i;
  logic [ADDR_WIDTH-1:0] ex_jump_addr_i;
  logic                  ex_div_start_i;
  logic                  ex_div_ready_i;
  logic                  mem_busy_i;
  logic                  cnt_clr_i;
  logic [4:0]            stall_o;
  logic                  flush_o;
  logic                  pc_jump_o;
  logic [ADDR_WIDTH-1:0] pc_jump_addr_o;
  logic                  div_abort_o;
  logic [CNT_WIDTH-1:0]  stall_cnt_o;
  logic [CNT_WIDTH-1:0]  flush_cnt_o;
  logic                  state_o;

  // Handshake: ex_div_start_i and ex_div_ready_i are single-cycle pulses
  // from the divider, and there is no back-pressure. div_abort_o is a
  // single-cycle pulse that the divider must obey by cancelling its operation.
  modport master (
    output id_stallreq_i, ex_jump_flag_i, ex_jump_addr_i, ex_div_start_i,
           ex_div_ready_i, mem_busy_i, cnt_clr_i,
    input  stall_o, flush_o, pc_jump_o, pc_jump_addr_o, div_abort_o,
           stall_cnt_o, flush_cnt_o, state_o
  );

  modport slave (
    input  id_stallreq_i, ex_jump_flag_i, ex_jump_addr_i, ex_div_start_i,
           ex_div_ready_i, mem_busy_i, cnt_clr_i,
    output stall_o, flush_o, pc_jump_o, pc_jump_addr_o, div_abort_o,
           stall_cnt_o, flush_cnt_o, state_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller for the 5-stage core. It merges the stall and flush sources into
// a per-stage hold vector, runs the divider-wait timeout FSM and keeps stall/flush counters.
module pipe_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DIV_TIMEOUT = 40,
  parameter int CNT_WIDTH   = 32
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  pipe_ctrl_if.slave bus
);

  localparam int TW = $clog2(DIV_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(DIV_TIMEOUT - 1);

  typedef enum logic {
    RUN      = 1'b0,
    DIV_WAIT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 abort_q, abort_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic [4:0]            stall;
  logic                  flush;
  logic                  pc_jump;
  logic [ADDR_WIDTH-1:0] pc_jump_addr;

  // Hold/flush merge. The outputs are forced quiet while reset is asserted.
  always_comb begin
    stall        = 5'b00000;
    flush        = 1'b0;
    pc_jump      = 1'b0;
    pc_jump_addr = '0;
    if (rst_n_i) begin
      if (bus.mem_busy_i) begin
        stall = 5'b01111;
      end else if (state_q == DIV_WAIT && !bus.ex_div_ready_i) begin
        stall = 5'b00111;
      end else if (bus.ex_jump_flag_i) begin
        flush        = 1'b1;
        pc_jump      = 1'b1;
        pc_jump_addr = bus.ex_jump_addr_i;
      end else if (bus.id_stallreq_i) begin
        stall = 5'b00011;
      end
    end
  end

  // Divider wait FSM. A memory stall does not freeze it, so ready or the
  // timeout is never missed.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    abort_d = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.ex_div_start_i && !bus.ex_div_ready_i && !bus.ex_jump_flag_i) begin
          state_d = DIV_WAIT;
          tmo_d   = '0;
        end
      end
      DIV_WAIT: begin
        if (bus.ex_div_ready_i) begin
          state_d = RUN;
        end else if (tmo_q == TMO_LAST) begin
          state_d = RUN;
          abort_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Saturating counters. A clear takes priority over an increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.cnt_clr_i) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall != 5'b00000 && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush && !(&flush_cnt_q))             flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= RUN;
      tmo_q       <= '0;
      abort_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      abort_q     <= abort_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_o        = stall;
  assign bus.flush_o        = flush;
  assign bus.pc_jump_o      = pc_jump;
  assign bus.pc_jump_addr_o = pc_jump_addr;
  assign bus.div_abort_o    = abort_q;
  assign bus.stall_cnt_o    = stall_cnt_q;
  assign bus.flush_cnt_o    = flush_cnt_q;
  assign bus.state_o        = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl. A second instance with 4-bit counters
// receives the same stimulus and is used for the saturation checks.
module tb_pipe_ctrl;

  logic clk_i;
  logic rst_n_i;
  int   checks;
  int   errors;

  pipe_ctrl_if #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) bus_m ();
  pipe_ctrl_if #(.ADDR_WIDTH(32), .CNT_WIDTH(4))  bus_s ();

  pipe_ctrl #(.ADDR_WIDTH(32), .DIV_TIMEOUT(40), .CNT_WIDTH(32)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus_m)
  );

  pipe_ctrl #(.ADDR_WIDTH(32), .DIV_TIMEOUT(40), .CNT_WIDTH(4)) dut_s (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus_s)
  );

  assign bus_s.id_stallreq_i  = bus_m.id_stallreq_i;
  assign bus_s.ex_jump_flag_i = bus_m.ex_jump_flag_i;
  assign bus_s.ex_jump_addr_i = bus_m.ex_jump_addr_i;
  assign bus_s.ex_div_start_i = bus_m.ex_div_start_i;
  assign bus_s.ex_div_ready_i = bus_m.ex_div_ready_i;
  assign bus_s.mem_busy_i     = bus_m.mem_busy_i;
  assign bus_s.cnt_clr_i      = bus_m.cnt_clr_i;

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus_m.id_stallreq_i  = 1'b0;
    bus_m.ex_jump_flag_i = 1'b0;
    bus_m.ex_jump_addr_i = 32'h0;
    bus_m.ex_div_start_i = 1'b0;
    bus_m.ex_div_ready_i = 1'b0;
    bus_m.mem_busy_i     = 1'b0;
    bus_m.cnt_clr_i      = 1'b0;
  endtask

  task automatic clear_counters();
    idle_inputs();
    bus_m.cnt_clr_i = 1'b1;
    tick();
    bus_m.cnt_clr_i = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();

    // reset with a memory stall pending
    rst_n_i          = 1'b0;
    bus_m.mem_busy_i = 1'b1;
    #3;
    check("rst_stall", bus_m.stall_o, 5'b00000);
    check("rst_flush", bus_m.flush_o, 1'b0);
    check("rst_pcjump", bus_m.pc_jump_o, 1'b0);
    repeat (2) tick();
    check("rst_stall_cnt", bus_m.stall_cnt_o, 32'd0);
    check("rst_flush_cnt", bus_m.flush_cnt_o, 32'd0);
    check("rst_abort", bus_m.div_abort_o, 1'b0);
    check("rst_state", bus_m.state_o, 1'b0);

    rst_n_i             = 1'b1;
    bus_m.mem_busy_i    = 1'b0;
    bus_m.id_stallreq_i = 1'b1;
    #1;
    check("ld_use_stall", bus_m.stall_o, 5'b00011);
    tick();
    bus_m.id_stallreq_i = 1'b0;
    check("ld_use_cnt", bus_m.stall_cnt_o, 32'd1);
    #1;
    check("idle_stall", bus_m.stall_o, 5'b00000);

    // jump beats load-use
    clear_counters();
    bus_m.ex_jump_flag_i = 1'b1;
    bus_m.ex_jump_addr_i = 32'h0000_0100;
    bus_m.id_stallreq_i  = 1'b1;
    #1;
    check("jmp_flush", bus_m.flush_o, 1'b1);
    check("jmp_pc", bus_m.pc_jump_o, 1'b1);
    check("jmp_addr", bus_m.pc_jump_addr_o, 32'h100);
    check("jmp_stall", bus_m.stall_o, 5'b00000);
    tick();
    idle_inputs();
    check("jmp_flush_cnt", bus_m.flush_cnt_o, 32'd1);
    check("jmp_stall_cnt", bus_m.stall_cnt_o, 32'd0);
    #1;
    check("nojmp_addr", bus_m.pc_jump_addr_o, 32'h0);

    // memory stall suppresses a jump
    bus_m.mem_busy_i     = 1'b1;
    bus_m.ex_jump_flag_i = 1'b1;
    bus_m.ex_jump_addr_i = 32'h0000_0200;
    #1;
    check("mem_jmp_stall", bus_m.stall_o, 5'b01111);
    check("mem_jmp_flush", bus_m.flush_o, 1'b0);
    check("mem_jmp_addr", bus_m.pc_jump_addr_o, 32'h0);
    tick();
    idle_inputs();

    // start and ready together: complete, stay in RUN
    bus_m.ex_div_start_i = 1'b1;
    bus_m.ex_div_ready_i = 1'b1;
    tick();
    idle_inputs();
    check("div_same_state", bus_m.state_o, 1'b0);
    // start alongside a jump is dropped
    bus_m.ex_div_start_i = 1'b1;
    bus_m.ex_jump_flag_i = 1'b1;
    tick();
    idle_inputs();
    check("div_jmp_state", bus_m.state_o, 1'b0);

    // divide: five stalled cycles, then ready
    clear_counters();
    bus_m.ex_div_start_i = 1'b1;
    #1;
    check("div_start_stall", bus_m.stall_o, 5'b00000);
    tick();
    bus_m.ex_div_start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("div_wait_stall", bus_m.stall_o, 5'b00111);
      check("div_wait_state", bus_m.state_o, 1'b1);
      tick();
    end
    bus_m.ex_div_ready_i = 1'b1;
    #1;
    check("div_ready_stall", bus_m.stall_o, 5'b00000);
    tick();
    bus_m.ex_div_ready_i = 1'b0;
    check("div_done_state", bus_m.state_o, 1'b0);
    check("div_stall_cnt", bus_m.stall_cnt_o, 32'd5);
    check("div_no_abort", bus_m.div_abort_o, 1'b0);

    // divider timeout after 40 wait cycles
    bus_m.ex_div_start_i = 1'b1;
    tick();
    bus_m.ex_div_start_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      check("tmo_stall", bus_m.stall_o, 5'b00111);
      check("tmo_abort_low", bus_m.div_abort_o, 1'b0);
      tick();
    end
    check("tmo_abort", bus_m.div_abort_o, 1'b1);
    check("tmo_state", bus_m.state_o, 1'b0);
    check("tmo_stall_rel", bus_m.stall_o, 5'b00000);
    tick();
    check("tmo_abort_pulse", bus_m.div_abort_o, 1'b0);

    // memory stall overrides a divider wait; ready lands mid-stall
    bus_m.ex_div_start_i = 1'b1;
    tick();
    bus_m.ex_div_start_i = 1'b0;
    bus_m.ex_jump_flag_i = 1'b1;
    bus_m.ex_jump_addr_i = 32'h0000_0300;
    bus_m.id_stallreq_i  = 1'b1;
    #1;
    check("dw_jmp_stall", bus_m.stall_o, 5'b00111);
    check("dw_jmp_flush", bus_m.flush_o, 1'b0);
    check("dw_jmp_pc", bus_m.pc_jump_o, 1'b0);
    tick();
    idle_inputs();
    bus_m.mem_busy_i = 1'b1;
    #1;
    check("mo_stall1", bus_m.stall_o, 5'b01111);
    tick();
    bus_m.ex_div_ready_i = 1'b1;
    #1;
    check("mo_stall2", bus_m.stall_o, 5'b01111);
    tick();
    bus_m.ex_div_ready_i = 1'b0;
    check("mo_state_run", bus_m.state_o, 1'b0);
    check("mo_stall3", bus_m.stall_o, 5'b01111);
    tick();
    bus_m.mem_busy_i = 1'b0;
    #1;
    check("mo_release", bus_m.stall_o, 5'b00000);
    check("mo_state", bus_m.state_o, 1'b0);

    // saturation on the 4-bit build, then clear during a stall
    clear_counters();
    bus_m.id_stallreq_i = 1'b1;
    repeat (16) tick();
    check("sat_small", bus_s.stall_cnt_o, 4'hF);
    check("sat_wide", bus_m.stall_cnt_o, 32'd16);
    tick();
    check("sat_hold", bus_s.stall_cnt_o, 4'hF);
    bus_m.cnt_clr_i = 1'b1;
    tick();
    bus_m.cnt_clr_i = 1'b0;
    check("clr_small", bus_s.stall_cnt_o, 4'h0);
    check("clr_wide", bus_m.stall_cnt_o, 32'd0);
    tick();
    check("clr_resume", bus_m.stall_cnt_o, 32'd1);
    idle_inputs();

    // reset mid-divide returns to RUN without an abort
    bus_m.ex_div_start_i = 1'b1;
    tick();
    bus_m.ex_div_start_i = 1'b0;
    check("rd_state_wait", bus_m.state_o, 1'b1);
    rst_n_i = 1'b0;
    #1;
    check("rd_state", bus_m.state_o, 1'b0);
    check("rd_stall", bus_m.stall_o, 5'b00000);
    tick();
    rst_n_i = 1'b1;
    tick();
    check("rd_abort", bus_m.div_abort_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage RV32I core (IF, ID, EX, MEM, WB). It merges stall and flush sources into one per-stage hold vector and one flush strobe. The sources are the ID load-use stall request, the EX jump/branch redirect, a multi-cycle divider handshake in EX, and the data-memory wait. It sequences divider waits with a timeout FSM and keeps saturating performance counters for stall and flush cycles.

Parameters:
ADDR_WIDTH, 32, PC/jump target width
DIV_TIMEOUT, 40, max cycles spent in DIV_WAIT before abort (>=2)
CNT_WIDTH, 32, width of performance counters

Ports:
clk_i  input  1  core clock
rst_n_i  input  1  asynchronous active-low reset
id_stallreq_i  input  1  load-use hazard request from decode
ex_jump_flag_i  input  1  EX resolved taken jump/branch
ex_jump_addr_i  input  ADDR_WIDTH  redirect target
ex_div_start_i  input  1  divider accepted an operation this cycle (1-cycle pulse)
ex_div_ready_i  input  1  divider result valid (1-cycle pulse)
mem_busy_i  input  1  data memory not ready; MEM stage must hold
cnt_clr_i  input  1  synchronous clear of both counters
stall_o  output  5  hold enables: [0] pc, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb
flush_o  output  1  replace if_id and id_ex contents with NOP
pc_jump_o  output  1  load PC with pc_jump_addr_o
pc_jump_addr_o  output  ADDR_WIDTH  redirect target
div_abort_o  output  1  1-cycle pulse: divider timed out, divider must cancel
stall_cnt_o  output  CNT_WIDTH  cycles with stall_o != 0
flush_cnt_o  output  CNT_WIDTH  cycles with flush_o = 1

Behaviour:
- Reset (rst_n_i low, async): state=RUN, timeout counter=0, counters=0, div_abort_o=0. Combinational outputs are forced to 0 while reset is low: stall_o=0, flush_o=0, pc_jump_o=0, pc_jump_addr_o=0. Reset mid-divide returns to RUN with no abort pulse.
- Outputs stall_o, flush_o, pc_jump_o and pc_jump_addr_o are combinational from state and inputs, with 0-cycle latency. State, timeout counter, div_abort_o and the counters are registered.
- FSM states: RUN and DIV_WAIT.
- RUN to DIV_WAIT: ex_div_start_i=1 and ex_div_ready_i=0 and ex_jump_flag_i=0.
- Start and ready in the same cycle: treated as complete, no stall, stay in RUN.
- DIV_WAIT to RUN: either of
  - ex_div_ready_i=1, or
  - timeout counter == DIV_TIMEOUT-1 with no ready; div_abort_o pulses high the following cycle for exactly 1 cycle.
- Timeout counter: cleared on entry to DIV_WAIT, increments every DIV_WAIT cycle.
- Stall vector priority, highest first:
  1. mem_busy_i=1: stall_o=5'b01111 (bubble into mem_wb), flush_o=0, pc_jump_o=0. This applies in any state, and the FSM still advances on ready/timeout.
  2. state=DIV_WAIT and ex_div_ready_i=0: stall_o=5'b00111 (bubble into ex_mem). ex_jump_flag_i and id_stallreq_i are ignored.
  3. ex_jump_flag_i=1: stall_o=0, flush_o=1, pc_jump_o=1, pc_jump_addr_o=ex_jump_addr_i. A simultaneous id_stallreq_i or ex_div_start_i is ignored, because the flushed instruction does not execute.
  4. id_stallreq_i=1: stall_o=5'b00011 (bubble into id_ex).
  5. Otherwise all outputs are 0.
- A suppressed jump (case 1) is not latched. The EX instruction is held, so ex_jump_flag_i reasserts once the stall releases.
- pc_jump_addr_o = 0 whenever pc_jump_o=0.
- Counters:
  - Each increments by 1 in any cycle its condition holds.
  - Each saturates at all-ones and does not wrap.
  - cnt_clr_i=1 zeroes both on the next edge and takes priority over increment.

Test Plan:
- Reset: drive rst_n_i=0 with mem_busy_i=1 -> stall_o=0, flush_o=0, counters 0. Release reset with id_stallreq_i=1 for 1 cycle -> stall_o=5'b00011, stall_cnt_o=1 next cycle.
- Jump vs load-use: ex_jump_flag_i=1, ex_jump_addr_i=32'h0000_0100, id_stallreq_i=1 -> flush_o=1, pc_jump_o=1, pc_jump_addr_o=32'h100, stall_o=0, flush_cnt_o increments.
- Divide: ex_div_start_i pulse, ex_div_ready_i pulse 5 cycles later -> stall_o=5'b00111 for the 5 intervening cycles. In the ready cycle stall_o=0 and state=RUN; stall_cnt_o=5.
- Timeout with DIV_TIMEOUT=40: start, no ready -> stall_o=5'b00111 for 40 cycles, then div_abort_o high exactly 1 cycle, stall_o=0, state=RUN.
- Memory overrides: in DIV_WAIT assert mem_busy_i for 3 cycles with ex_div_ready_i in the 2nd -> stall_o=5'b01111 for those 3 cycles, FSM in RUN after the ready, stall_o=0 once mem_busy_i drops.
- Saturation/clear: preload via 2^CNT_WIDTH stall cycles (CNT_WIDTH=4 build) -> stall_cnt_o holds 4'hF. cnt_clr_i=1 concurrent with a stall -> 0 next cycle.
